// File: rtl/seq_detector_1011.sv
// Serial 1011 pattern detector (Moore, overlapping) with a saturating
// detection counter. Consumes one bit of D on every clock edge where en=1.
// The state code is exported so waveforms show the FSM progress directly.
module seq_detector_1011 #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             D,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       state
);

    // Each state names the longest pattern prefix seen so far.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // nothing useful
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "10"
        S3 = 3'd3,  // "101"
        S4 = 3'd4   // "1011" -- match
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Kept as a raw 3-bit vector so the unused codes 5-7 are representable
    // and recoverable rather than hidden behind the enum type.
    logic [2:0]       state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             hit;

    // Next-state logic; illegal codes fall back to S0 even when en=0.
    always_comb begin
        state_d = state_t'(state_q);
        hit     = 1'b0;
        case (state_q)
            S0: if (en) state_d = D ? S1 : S0;
            S1: if (en) state_d = D ? S1 : S2;
            S2: if (en) state_d = D ? S3 : S0;
            S3: if (en) begin
                    state_d = D ? S4 : S2;
                    hit     = D;
                end
            S4: if (en) state_d = D ? S1 : S2;  // overlap: reuse "1" / "10"
            default: state_d = S0;
        endcase
    end

    // Detection counter: credit only the S3->S4 edge, stop at all-ones.
    always_comb begin
        count_d = count_q;
        if (hit && (count_q != CNT_MAX))
            count_d = count_q + CNT_W'(1);
    end

    // State and counter registers; clear wipes any partial prefix and the tally.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= S0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Moore outputs straight from the registers; no path from D or en.
    assign match = (state_q == S4);
    assign count = count_q;
    assign state = state_q;

    // The tally must never go backwards while out of reset.
    a_count_monotonic: assert property (
        @(posedge clk) disable iff (!clear) 1'b1 |=> count_q >= $past(count_q)
    );

endmodule

// File: tb/tb_seq_detector_1011.sv
// Bench for seq_detector_1011: a table of overlap vectors, hand-written
// corner sequences, and random traffic checked against a prefix-history model.
module tb_seq_detector_1011;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic       D = 1'b0;
    logic       match, match_s;
    logic [3:0] count;
    logic [1:0] count_s;
    logic [2:0] state, state_s;

    int n_cmp = 0;
    int n_err = 0;

    // model: last up-to-4 consumed bits since reset, and saturating tallies
    logic [3:0] hist = '0;
    int         hlen = 0;
    int         mc4 = 0;
    int         mc2 = 0;

    always #5 clk = ~clk;

    seq_detector_1011 dut (
        .clk(clk), .clear(clear), .en(en), .D(D),
        .match(match), .count(count), .state(state)
    );

    seq_detector_1011 #(.CNT_W(2)) dut_s (
        .clk(clk), .clear(clear), .en(en), .D(D),
        .match(match_s), .count(count_s), .state(state_s)
    );

    typedef struct {
        logic       en;
        logic       d;
        logic [2:0] st;
        logic       m;
        logic [3:0] c;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Longest suffix of the consumed stream that is a prefix of 1011.
    function automatic int model_state();
        if (hlen >= 4 && hist == 4'b1011) return 4;
        if (hlen >= 3 && hist[2:0] == 3'b101) return 3;
        if (hlen >= 2 && hist[1:0] == 2'b10) return 2;
        if (hlen >= 1 && hist[0]) return 1;
        return 0;
    endfunction

    // One clock: drive at negedge, update model at posedge, check at negedge.
    task automatic tick(input logic e, input logic dv);
        int ms;
        en = e;
        D  = dv;
        @(posedge clk);
        if (e) begin
            hist = {hist[2:0], dv};
            if (hlen < 4) hlen++;
        end
        ms = model_state();
        if (e && ms == 4) begin
            if (mc4 < 15) mc4++;
            if (mc2 < 3) mc2++;
        end
        @(negedge clk);
        chk("mdl_state", 16'(state), 16'(ms));
        chk("mdl_match", 16'(match), 16'(ms == 4));
        chk("mdl_count", 16'(count), 16'(mc4));
        chk("mdl_state_s", 16'(state_s), 16'(ms));
        chk("mdl_count_s", 16'(count_s), 16'(mc2));
    endtask

    // Assert clear between edges and check it acts before any clock edge.
    task automatic do_clear();
        clear = 1'b0;
        #1;
        chk("clr_state", 16'(state), 16'd0);
        chk("clr_match", 16'(match), 16'd0);
        chk("clr_count", 16'(count), 16'd0);
        chk("clr_count_s", 16'(count_s), 16'd0);
        hist = '0;
        hlen = 0;
        mc4  = 0;
        mc2  = 0;
        @(negedge clk);
        clear = 1'b1;
    endtask

    initial begin : main
        logic [7:0]  nm_bits;
        logic [12:0] sat_bits;
        logic [3:0]  cnt_before;
        int          sat_exp[13];

        // overlap stream 1,0,1,1,0,1,1 with expectations written out
        tbl[0] = '{1'b1, 1'b1, 3'd1, 1'b0, 4'd0};
        tbl[1] = '{1'b1, 1'b0, 3'd2, 1'b0, 4'd0};
        tbl[2] = '{1'b1, 1'b1, 3'd3, 1'b0, 4'd0};
        tbl[3] = '{1'b1, 1'b1, 3'd4, 1'b1, 4'd1};
        tbl[4] = '{1'b1, 1'b0, 3'd2, 1'b0, 4'd1};
        tbl[5] = '{1'b1, 1'b1, 3'd3, 1'b0, 4'd1};
        tbl[6] = '{1'b1, 1'b1, 3'd4, 1'b1, 4'd2};

        // reset state (clear low across a rising edge)
        @(negedge clk);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_match", 16'(match), 16'd0);
        chk("rst_count", 16'(count), 16'd0);
        clear = 1'b1;

        // overlap table
        for (int i = 0; i < 7; i++) begin
            tick(tbl[i].en, tbl[i].d);
            chk($sformatf("tbl%0d_state", i), 16'(state), 16'(tbl[i].st));
            chk($sformatf("tbl%0d_match", i), 16'(match), 16'(tbl[i].m));
            chk($sformatf("tbl%0d_count", i), 16'(count), 16'(tbl[i].c));
        end

        // reset mid-pattern: reach S3 with count=2, then clear
        do_clear();
        tick(1, 1); tick(1, 0); tick(1, 1); tick(1, 1);
        tick(1, 0); tick(1, 1); tick(1, 1); tick(1, 0); tick(1, 1);
        chk("pre_rst_state", 16'(state), 16'd3);
        chk("pre_rst_count", 16'(count), 16'd2);
        do_clear();
        tick(1, 1); tick(1, 0); tick(1, 1); tick(1, 1);
        chk("post_rst_match", 16'(match), 16'd1);
        chk("post_rst_count", 16'(count), 16'd1);

        // non-matching stream 1,0,1,0,0,1,1,1
        do_clear();
        nm_bits = 8'b10100111;
        for (int i = 7; i >= 0; i--) begin
            tick(1, nm_bits[i]);
            chk("nm_match", 16'(match), 16'd0);
        end
        chk("nm_state", 16'(state), 16'd1);
        chk("nm_count", 16'(count), 16'd0);

        // enable gating: hold in S3 while D toggles
        do_clear();
        tick(1, 1); tick(1, 0); tick(1, 1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1'(i));
            chk("gate_hold", 16'(state), 16'd3);
        end
        tick(1, 1);
        chk("gate_state", 16'(state), 16'd4);
        chk("gate_match", 16'(match), 16'd1);
        chk("gate_count", 16'(count), 16'd1);
        // en low in S4: match must persist until the next enabled edge
        tick(0, 0); tick(0, 1);
        chk("gate_match_hold", 16'(match), 16'd1);
        tick(1, 0);
        chk("gate_match_drop", 16'(match), 16'd0);

        // saturation on the 2-bit instance: counts 1,2,3,3 at the match edges
        do_clear();
        sat_bits = 13'b1011011011011;
        sat_exp  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3};
        for (int i = 0; i < 13; i++) begin
            tick(1, sat_bits[12-i]);
            chk($sformatf("sat%0d_count", i), 16'(count_s), 16'(sat_exp[i]));
            chk($sformatf("sat%0d_match", i), 16'(match_s),
                16'((i == 3) || (i == 6) || (i == 9) || (i == 12)));
        end

        // saturation on the 4-bit instance: 20 overlapping matches
        do_clear();
        tick(1, 1);
        for (int i = 0; i < 20; i++) begin
            tick(1, 0); tick(1, 1); tick(1, 1);
        end
        chk("sat4_count", 16'(count), 16'd15);

        // illegal code 6 -> S0 on next edge even with en=0, count kept
        tick(1, 0);
        cnt_before = count;
        en = 1'b0;
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        #1;
        chk("ill_state_forced", 16'(state), 16'd6);
        chk("ill_match_forced", 16'(match), 16'd0);
        @(posedge clk);
        @(negedge clk);
        chk("ill_state", 16'(state), 16'd0);
        chk("ill_match", 16'(match), 16'd0);
        chk("ill_count", 16'(count), 16'(cnt_before));

        // random traffic against the model, with occasional clears
        do_clear();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0)
                do_clear();
            else
                tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
